fix_to_float: RTL

FIX_TO_FLOAT -- requirements
Module: fix_to_float

---
 rtl/fix_to_float_if.sv | 30 +++
 rtl/fix_to_float.sv | 104 ++++++++++
 2 files changed

// File: rtl/fix_to_float_if.sv
// Streaming handshake bundle for the fixed-point to binary32 converter.
// The slave side is the converter; the master side feeds inputs and drains results.
interface fix_to_float_if #(
    parameter int W = 77
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/fix_to_float.sv
// Signed Q(INT_BITS).(FRAC_BITS) fixed point to IEEE 754 binary32 converter.
// Normalises one bit per cycle, then rounds to nearest-even in a single step.
//
// state | meaning
// IDLE  | waiting for an input transfer, in_ready high
// NORM  | shifting magnitude left until its top bit is set, then rounding
// DONE  | result presented on out_data/out_valid until out_ready
module fix_to_float #(
    parameter int FRAC_BITS = 32,
    parameter int INT_BITS  = 44
) (
    input logic           clk,
    input logic           rst_n,
    fix_to_float_if.slave bus
);
    localparam int W = INT_BITS + FRAC_BITS + 1;
    localparam logic [9:0] EXP_INIT = 10'(W - 1 - FRAC_BITS + 127);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic          sign;
    logic [W-1:0]  mag;
    logic [9:0]    exp_q;
    logic [31:0]   out_q;

    logic [W-1:0]  abs_in;
    logic [W+23:0] ext;
    logic [22:0]   mant;
    logic          lsb;
    logic          guard;
    logic          sticky;
    logic [23:0]   mant_inc;
    logic [22:0]   mant_rnd;
    logic [7:0]    exp_rnd;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_q;

    // Magnitude of the incoming value; the most negative input wraps to 2^(W-1) as intended.
    always_comb begin
        abs_in = bus.in_data;
        if (bus.in_data[W-1]) begin
            abs_in = ~bus.in_data + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Round-to-nearest-even on the normalised magnitude. Zero padding below mag keeps
    // the guard/sticky slices valid even for very narrow fixed-point formats.
    always_comb begin
        ext      = {mag[W-2:0], 25'd0};
        mant     = ext[W+23:W+1];
        lsb      = ext[W+1];
        guard    = ext[W];
        sticky   = |ext[W-1:0];
        mant_inc = {1'b0, mant} + {23'd0, guard & (lsb | sticky)};
        mant_rnd = mant_inc[22:0];
        exp_rnd  = exp_q[7:0] + {7'd0, mant_inc[23]};
    end

    // Control FSM and datapath registers. A zero input spends one cycle in NORM so
    // its latency matches a value whose leading one is already at the top bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sign  <= 1'b0;
            mag   <= '0;
            exp_q <= '0;
            out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign  <= bus.in_data[W-1];
                        mag   <= abs_in;
                        exp_q <= EXP_INIT;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (mag == '0) begin
                        out_q <= '0;
                        state <= DONE;
                    end else if (mag[W-1]) begin
                        out_q <= {sign, exp_rnd, mant_rnd};
                        state <= DONE;
                    end else begin
                        mag   <= mag << 1;
                        exp_q <= exp_q - 10'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
